prf_bypass: RTL and testbench

//  Parametrised physical register file for the R10K-style core. Provides RD_PORTS reads,
//  WR_PORTS writes and INV_PORTS invalidates per cycle, plus a per-entry valid bit and a

---
 rtl/prf_bypass_pkg.sv | 23 ++
 rtl/prf_bypass_if.sv | 32 +++
 rtl/prf_bypass_read_port.sv | 51 +++++
 rtl/prf_bypass.sv | 121 ++++++++++++
 tb/tb_prf_bypass.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prf_bypass_pkg.sv
// Shared types and sizing for the physical register file with write->read bypass.
// PRN width follows the physical register count, so one PRN value can name every entry.
package prf_bypass_pkg;

    localparam int N                = 2;
    localparam int PHYS_REG_SZ_R10K = 32;
    localparam int PRN_W            = $clog2(PHYS_REG_SZ_R10K);
    localparam int DATA_W           = 32;

    typedef logic [PRN_W-1:0]  PRN;
    typedef logic [DATA_W-1:0] DATA;

    typedef struct packed {
        logic valid;
        DATA  value;
    } PRF_ENTRY;

    typedef struct packed {
        DATA value;
        PRN  prn;
    } PRF_WRITE;

endpackage

// File: rtl/prf_bypass_if.sv
// Bundles the register file's read, write, invalidate and debug signals.
// The issue/writeback side drives through master; the register file uses slave.
interface prf_bypass_if
    import prf_bypass_pkg::*;
#(
    parameter int NUM_PRN   = PHYS_REG_SZ_R10K,
    parameter int RD_PORTS  = 2*N,
    parameter int WR_PORTS  = N,
    parameter int INV_PORTS = N
) ();

    localparam int CNT_W = $clog2(NUM_PRN) + 1;

    logic             clear;
    PRN               read_prn     [RD_PORTS];
    PRF_ENTRY         output_value [RD_PORTS];
    PRF_WRITE         write_data   [WR_PORTS];
    PRN               prn_invalid  [INV_PORTS];
    PRF_ENTRY         entries_out  [NUM_PRN];
    logic [CNT_W-1:0] counter;

    modport master (
        output clear, read_prn, write_data, prn_invalid,
        input  output_value, entries_out, counter
    );

    modport slave (
        input  clear, read_prn, write_data, prn_invalid,
        output output_value, entries_out, counter
    );

endinterface

// File: rtl/prf_bypass_read_port.sv
// One combinational read port: looks up the stored entry and, when enabled, forwards
// a same-cycle write, dropping the valid bit if that PRN is invalidated or cleared.
module prf_bypass_read_port
    import prf_bypass_pkg::*;
#(
    parameter int NUM_PRN   = PHYS_REG_SZ_R10K,
    parameter int WR_PORTS  = N,
    parameter int INV_PORTS = N,
    parameter bit BYPASS    = 1'b1
) (
    input  PRF_ENTRY entries_i     [NUM_PRN],
    input  PRF_WRITE write_data_i  [WR_PORTS],
    input  PRN       prn_invalid_i [INV_PORTS],
    input  logic     clear_i,
    input  PRN       read_prn_i,
    output PRF_ENTRY entry_o
);

    PRF_ENTRY stored;
    logic     hit;
    logic     kill;
    DATA      fwd;

    // Later write ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        stored = '0;
        hit    = 1'b0;
        kill   = clear_i;
        fwd    = '0;
        for (int p = 0; p < NUM_PRN; p++) begin
            if (read_prn_i == PRN'(p)) stored = entries_i[p];
        end
        for (int w = 0; w < WR_PORTS; w++) begin
            if (write_data_i[w].prn == read_prn_i) begin
                hit = 1'b1;
                fwd = write_data_i[w].value;
            end
        end
        for (int i = 0; i < INV_PORTS; i++) begin
            if (prn_invalid_i[i] == read_prn_i) kill = 1'b1;
        end
        entry_o = stored;
        if (read_prn_i == '0) begin
            entry_o = '0;
        end else if (BYPASS && hit) begin
            entry_o.valid = ~kill;
            entry_o.value = fwd;
        end
    end

endmodule

// File: rtl/prf_bypass.sv
// Physical register file: per-entry valid/value, multi-port write/invalidate/clear,
// bypassed combinational reads and a registered count of valid entries.
module prf_bypass
    import prf_bypass_pkg::*;
#(
    parameter int NUM_PRN   = PHYS_REG_SZ_R10K,
    parameter int RD_PORTS  = 2*N,
    parameter int WR_PORTS  = N,
    parameter int INV_PORTS = N,
    parameter bit BYPASS    = 1'b1
) (
    input logic         clock,
    input logic         reset,
    prf_bypass_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_PRN) + 1;

    logic [NUM_PRN-1:0] valid_q;
    logic [NUM_PRN-1:0] valid_d;
    DATA                value_q [NUM_PRN];
    DATA                value_d [NUM_PRN];
    logic [CNT_W-1:0]   counter_q;
    logic [CNT_W-1:0]   counter_d;

    PRF_ENTRY table_w [NUM_PRN];
    PRF_ENTRY port_w  [RD_PORTS];
    PRF_ENTRY rd_out  [RD_PORTS];

    logic hit;
    logic kill;
    DATA  wval;

    // Clear beats invalidate beats write; PRN 0 is never touched.
    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        hit     = 1'b0;
        kill    = 1'b0;
        wval    = '0;
        for (int p = 1; p < NUM_PRN; p++) begin
            hit  = 1'b0;
            kill = bus.clear;
            wval = '0;
            for (int w = 0; w < WR_PORTS; w++) begin
                if (bus.write_data[w].prn == PRN'(p)) begin
                    hit  = 1'b1;
                    wval = bus.write_data[w].value;
                end
            end
            for (int i = 0; i < INV_PORTS; i++) begin
                if (bus.prn_invalid[i] == PRN'(p)) kill = 1'b1;
            end
            if (kill) begin
                valid_d[p] = 1'b0;
            end else if (hit) begin
                valid_d[p] = 1'b1;
                value_d[p] = wval;
            end
        end
        valid_d[0] = 1'b0;
    end

    always_comb begin
        counter_d = '0;
        for (int p = 0; p < NUM_PRN; p++) begin
            counter_d = counter_d + CNT_W'(valid_d[p]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            counter_q <= '0;
        end else begin
            valid_q   <= valid_d;
            counter_q <= counter_d;
        end
    end

    // Values carry no reset; they only matter once the valid bit is set.
    always_ff @(posedge clock) begin
        value_q <= value_d;
    end

    always_comb begin
        for (int p = 0; p < NUM_PRN; p++) begin
            table_w[p].valid = valid_q[p];
            table_w[p].value = value_q[p];
        end
    end

    for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
        prf_bypass_read_port #(
            .NUM_PRN   (NUM_PRN),
            .WR_PORTS  (WR_PORTS),
            .INV_PORTS (INV_PORTS),
            .BYPASS    (BYPASS)
        ) u_rd (
            .entries_i     (table_w),
            .write_data_i  (bus.write_data),
            .prn_invalid_i (bus.prn_invalid),
            .clear_i       (bus.clear),
            .read_prn_i    (bus.read_prn[r]),
            .entry_o       (port_w[r])
        );
    end

    // A forwarded write must not appear valid while the file is held in reset.
    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rd_out[r] = port_w[r];
            if (!reset) rd_out[r].valid = 1'b0;
        end
    end

    assign bus.output_value = rd_out;
    assign bus.entries_out  = table_w;
    assign bus.counter      = counter_q;

endmodule

// File: tb/tb_prf_bypass.sv
// Directed and randomised checks of prf_bypass, run side by side with BYPASS=1 (A)
// and BYPASS=0 (B) instances fed from the same stimulus.
module tb_prf_bypass;
    import prf_bypass_pkg::*;

    localparam int NP  = 32;
    localparam int RD  = 4;
    localparam int WR  = 2;
    localparam int INV = 2;

    logic     clock = 1'b0;
    logic     reset = 1'b0;
    logic     clr;
    PRN       rd  [RD];
    PRF_WRITE wr  [WR];
    PRN       inv [INV];

    int errors = 0;
    int checks = 0;

    bit  mv [NP];
    DATA md [NP];

    always #5 clock = ~clock;

    prf_bypass_if #(.NUM_PRN(NP), .RD_PORTS(RD), .WR_PORTS(WR), .INV_PORTS(INV)) busA ();
    prf_bypass_if #(.NUM_PRN(NP), .RD_PORTS(RD), .WR_PORTS(WR), .INV_PORTS(INV)) busB ();

    assign busA.clear       = clr;
    assign busA.read_prn    = rd;
    assign busA.write_data  = wr;
    assign busA.prn_invalid = inv;
    assign busB.clear       = clr;
    assign busB.read_prn    = rd;
    assign busB.write_data  = wr;
    assign busB.prn_invalid = inv;

    prf_bypass #(.NUM_PRN(NP), .RD_PORTS(RD), .WR_PORTS(WR), .INV_PORTS(INV), .BYPASS(1'b1)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    prf_bypass #(.NUM_PRN(NP), .RD_PORTS(RD), .WR_PORTS(WR), .INV_PORTS(INV), .BYPASS(1'b0)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    task automatic idle();
        clr = 1'b0;
        for (int r = 0; r < RD; r++) rd[r] = '0;
        for (int w = 0; w < WR; w++) wr[w] = '0;
        for (int i = 0; i < INV; i++) inv[i] = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic PRF_ENTRY exp_read(PRN a, bit byp);
        PRF_ENTRY e;
        bit       hit;
        bit       kill;
        DATA      f;
        e    = '0;
        hit  = 1'b0;
        kill = clr;
        f    = '0;
        if (a == '0) return e;
        e.valid = mv[a];
        e.value = md[a];
        for (int w = 0; w < WR; w++) begin
            if (wr[w].prn == a) begin
                hit = 1'b1;
                f   = wr[w].value;
            end
        end
        for (int i = 0; i < INV; i++) if (inv[i] == a) kill = 1'b1;
        if (byp && hit) begin
            e.valid = ~kill;
            e.value = f;
        end
        return e;
    endfunction

    task automatic test_reset();
        int bad;
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rd[0] = PRN'(3);
        rd[1] = PRN'(31);
        wr[0].prn   = PRN'(3);
        wr[0].value = 32'h77;
        #4;
        checks++;
        if (busA.counter !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_counterA: got %0d expected 0", busA.counter);
        end
        checks++;
        if (busB.counter !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_counterB: got %0d expected 0", busB.counter);
        end
        bad = 0;
        for (int p = 0; p < NP; p++) if (busA.entries_out[p].valid !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_valids: got %0d valid entries expected 0", bad);
        end
        checks++;
        if (busA.output_value[0].valid !== 1'b0 || busA.output_value[1].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_read: got valid %b/%b expected 0/0",
                     busA.output_value[0].valid, busA.output_value[1].valid);
        end
        idle();
        reset = 1'b1;
        step();
        checks++;
        if (busA.counter !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_release_counter: got %0d expected 0", busA.counter);
        end
    endtask

    task automatic test_fill();
        int badA;
        int badB;
        for (int p = 1; p < NP; p += 2) begin
            idle();
            wr[0].prn   = PRN'(p);
            wr[0].value = DATA'(32'h1000 + p);
            if (p + 1 < NP) begin
                wr[1].prn   = PRN'(p + 1);
                wr[1].value = DATA'(32'h1000 + p + 1);
            end
            step();
        end
        idle();
        rd[2] = PRN'(31);
        #1;
        checks++;
        if (busA.counter !== 6'd31) begin
            errors++;
            $display("[TB] FAIL fill_counterA: got %0d expected 31", busA.counter);
        end
        checks++;
        if (busB.counter !== 6'd31) begin
            errors++;
            $display("[TB] FAIL fill_counterB: got %0d expected 31", busB.counter);
        end
        badA = 0;
        badB = 0;
        for (int p = 1; p < NP; p++) begin
            if (busA.entries_out[p].valid !== 1'b1 || busA.entries_out[p].value !== DATA'(32'h1000 + p)) badA++;
            if (busB.entries_out[p].valid !== 1'b1 || busB.entries_out[p].value !== DATA'(32'h1000 + p)) badB++;
        end
        checks++;
        if (badA != 0 || badB != 0) begin
            errors++;
            $display("[TB] FAIL fill_table: got %0d/%0d wrong entries expected 0", badA, badB);
        end
        checks++;
        if (busA.entries_out[0].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_prn0: got valid %b expected 0", busA.entries_out[0].valid);
        end
        checks++;
        if (busA.output_value[2] !== PRF_ENTRY'({1'b1, 32'h0000101F})) begin
            errors++;
            $display("[TB] FAIL fill_read31: got %h expected 10000101f", busA.output_value[2]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr[0].prn   = PRN'(5);
        wr[0].value = 32'hDEAD;
        rd[0]       = PRN'(5);
        #4;
        checks++;
        if (busA.output_value[0] !== PRF_ENTRY'({1'b1, 32'h0000DEAD})) begin
            errors++;
            $display("[TB] FAIL bypass_sameA: got %h expected 10000dead", busA.output_value[0]);
        end
        checks++;
        if (busB.output_value[0] !== PRF_ENTRY'({1'b1, 32'h00001005})) begin
            errors++;
            $display("[TB] FAIL bypass_sameB: got %h expected 100001005", busB.output_value[0]);
        end
        step();
        idle();
        rd[0] = PRN'(5);
        #1;
        checks++;
        if (busA.output_value[0] !== PRF_ENTRY'({1'b1, 32'h0000DEAD}) ||
            busB.output_value[0] !== PRF_ENTRY'({1'b1, 32'h0000DEAD})) begin
            errors++;
            $display("[TB] FAIL bypass_next: got %h/%h expected 10000dead", busA.output_value[0], busB.output_value[0]);
        end

        wr[0].prn   = PRN'(6);
        wr[0].value = 32'h66;
        inv[0]      = PRN'(6);
        rd[0]       = PRN'(6);
        wr[1].prn   = PRN'(0);
        wr[1].value = 32'h55;
        rd[1]       = PRN'(0);
        #4;
        checks++;
        if (busA.output_value[0].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass_killed: got valid %b expected 0", busA.output_value[0].valid);
        end
        checks++;
        if (busB.output_value[0] !== PRF_ENTRY'({1'b1, 32'h00001006})) begin
            errors++;
            $display("[TB] FAIL bypass_killedB: got %h expected 100001006", busB.output_value[0]);
        end
        checks++;
        if (busA.output_value[1] !== PRF_ENTRY'('0)) begin
            errors++;
            $display("[TB] FAIL bypass_prn0: got %h expected 0", busA.output_value[1]);
        end
        step();
        idle();
        rd[0] = PRN'(6);
        #1;
        checks++;
        if (busA.output_value[0].valid !== 1'b0 || busA.counter !== 6'd30) begin
            errors++;
            $display("[TB] FAIL bypass_inv6: got valid %b count %0d expected 0 and 30",
                     busA.output_value[0].valid, busA.counter);
        end
    endtask

    task automatic test_conflicts();
        idle();
        wr[0].prn   = PRN'(7);
        wr[0].value = 32'hA;
        wr[1].prn   = PRN'(7);
        wr[1].value = 32'hB;
        rd[0]       = PRN'(7);
        #4;
        checks++;
        if (busA.output_value[0] !== PRF_ENTRY'({1'b1, 32'h0000000B})) begin
            errors++;
            $display("[TB] FAIL dup_write_bypass: got %h expected 10000000b", busA.output_value[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (busA.entries_out[7] !== PRF_ENTRY'({1'b1, 32'h0000000B}) ||
            busB.entries_out[7] !== PRF_ENTRY'({1'b1, 32'h0000000B}) || busA.counter !== 6'd30) begin
            errors++;
            $display("[TB] FAIL dup_write_entry: got %h/%h count %0d expected 10000000b and 30",
                     busA.entries_out[7], busB.entries_out[7], busA.counter);
        end

        inv[0] = PRN'(9);
        inv[1] = PRN'(9);
        step();
        idle();
        #1;
        checks++;
        if (busA.counter !== 6'd29 || busA.entries_out[9].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dup_invalidate: got count %0d valid %b expected 29 and 0",
                     busA.counter, busA.entries_out[9].valid);
        end

        wr[0].prn   = PRN'(12);
        wr[0].value = 32'hC;
        inv[1]      = PRN'(12);
        step();
        idle();
        #1;
        checks++;
        if (busB.counter !== 6'd28 || busB.entries_out[12].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_and_invalidate: got count %0d valid %b expected 28 and 0",
                     busB.counter, busB.entries_out[12].valid);
        end
    endtask

    task automatic test_clear();
        int bad;
        idle();
        wr[0].prn   = PRN'(6);
        wr[0].value = 32'h1006;
        wr[1].prn   = PRN'(9);
        wr[1].value = 32'h1009;
        step();
        idle();
        wr[0].prn   = PRN'(12);
        wr[0].value = 32'h100C;
        step();
        idle();
        #1;
        checks++;
        if (busA.counter !== 6'd31) begin
            errors++;
            $display("[TB] FAIL clear_refill: got %0d expected 31", busA.counter);
        end
        clr         = 1'b1;
        wr[0].prn   = PRN'(3);
        wr[0].value = 32'h33;
        wr[1].prn   = PRN'(4);
        wr[1].value = 32'h44;
        rd[1]       = PRN'(3);
        #4;
        checks++;
        if (busA.output_value[1].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_bypass: got valid %b expected 0", busA.output_value[1].valid);
        end
        step();
        idle();
        #1;
        bad = 0;
        for (int p = 0; p < NP; p++) if (busA.entries_out[p].valid !== 1'b0) bad++;
        checks++;
        if (busA.counter !== 6'd0 || busB.counter !== 6'd0 || bad != 0) begin
            errors++;
            $display("[TB] FAIL clear_all: got counts %0d/%0d valid entries %0d expected 0",
                     busA.counter, busB.counter, bad);
        end
    endtask

    task automatic test_random();
        PRF_ENTRY ea;
        PRF_ENTRY eb;
        bit       nv [NP];
        DATA      nd [NP];
        bit       hit;
        bit       kill;
        DATA      f;
        int       badA;
        int       badB;
        int       cnt;
        for (int p = 0; p < NP; p++) begin
            mv[p] = 1'b0;
            md[p] = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            idle();
            clr = ($urandom_range(0, 63) == 0);
            for (int w = 0; w < WR; w++) begin
                wr[w].prn   = PRN'($urandom_range(0, NP - 1));
                wr[w].value = $urandom();
            end
            for (int i = 0; i < INV; i++) begin
                if ($urandom_range(0, 3) == 0) inv[i] = PRN'($urandom_range(0, NP - 1));
            end
            for (int r = 0; r < RD; r++) rd[r] = PRN'($urandom_range(0, NP - 1));
            if (c % 16 == 0) begin
                wr[1].prn = wr[0].prn;
                inv[1]    = inv[0];
                rd[0]     = wr[0].prn;
            end
            #4;
            badA = 0;
            badB = 0;
            for (int r = 0; r < RD; r++) begin
                ea = exp_read(rd[r], 1'b1);
                eb = exp_read(rd[r], 1'b0);
                if (busA.output_value[r].valid !== ea.valid ||
                    (ea.valid && busA.output_value[r].value !== ea.value)) badA++;
                if (busB.output_value[r].valid !== eb.valid ||
                    (eb.valid && busB.output_value[r].value !== eb.value)) badB++;
            end
            checks++;
            if (badA != 0) begin
                errors++;
                $display("[TB] FAIL random_readA cycle %0d: got %0d bad ports expected 0", c, badA);
            end
            checks++;
            if (badB != 0) begin
                errors++;
                $display("[TB] FAIL random_readB cycle %0d: got %0d bad ports expected 0", c, badB);
            end
            for (int p = 0; p < NP; p++) begin
                nv[p] = mv[p];
                nd[p] = md[p];
                if (p != 0) begin
                    hit  = 1'b0;
                    kill = clr;
                    f    = '0;
                    for (int w = 0; w < WR; w++) begin
                        if (wr[w].prn == PRN'(p)) begin
                            hit = 1'b1;
                            f   = wr[w].value;
                        end
                    end
                    for (int i = 0; i < INV; i++) if (inv[i] == PRN'(p)) kill = 1'b1;
                    if (kill) nv[p] = 1'b0;
                    else if (hit) begin
                        nv[p] = 1'b1;
                        nd[p] = f;
                    end
                end
            end
            step();
            cnt  = 0;
            badA = 0;
            for (int p = 0; p < NP; p++) begin
                mv[p] = nv[p];
                md[p] = nd[p];
                if (mv[p]) cnt++;
                if (busA.entries_out[p].valid !== mv[p] ||
                    (mv[p] && busA.entries_out[p].value !== md[p])) badA++;
            end
            checks++;
            if (busA.counter !== 6'(cnt) || badA != 0) begin
                errors++;
                $display("[TB] FAIL random_stateA cycle %0d: got count %0d bad entries %0d expected %0d and 0",
                         c, busA.counter, badA, cnt);
            end
            checks++;
            if (busB.counter !== 6'(cnt)) begin
                errors++;
                $display("[TB] FAIL random_countB cycle %0d: got %0d expected %0d", c, busB.counter, cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        int bad;
        idle();
        wr[0].prn   = PRN'(1);
        wr[0].value = 32'h11;
        wr[1].prn   = PRN'(2);
        wr[1].value = 32'h22;
        step();
        idle();
        wr[0].prn   = PRN'(8);
        wr[0].value = 32'h88;
        rd[0]       = PRN'(8);
        rd[1]       = PRN'(1);
        #2;
        reset = 1'b0;
        #1;
        bad = 0;
        for (int p = 0; p < NP; p++) begin
            if (busA.entries_out[p].valid !== 1'b0) bad++;
            if (busB.entries_out[p].valid !== 1'b0) bad++;
        end
        checks++;
        if (busA.counter !== 6'd0 || busB.counter !== 6'd0 || bad != 0) begin
            errors++;
            $display("[TB] FAIL async_reset_state: got counts %0d/%0d valid entries %0d expected 0",
                     busA.counter, busB.counter, bad);
        end
        checks++;
        if (busA.output_value[0].valid !== 1'b0 || busA.output_value[1].valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_read: got valid %b/%b expected 0/0",
                     busA.output_value[0].valid, busA.output_value[1].valid);
        end
        idle();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_bypass();
        test_conflicts();
        test_clear();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
